rbus_slot_arbiter: RTL and testbench

- Time-division scheduler that shares one rbus lane between REQ_NUM requesters, one frame slot per grant.
- Free-running slot counter cuts time into frames of FRAME_WORDS cycles; each frame boundary runs a round-robin pick and gives the next frame to the winner.
- Pops the winner's FWFT source with o_rd and emits a registered sof/ctrl/data stream, ready to feed the per-lane rbus frame generator.

---
 rtl/rbus_arb_pkg.sv | 31 +++
 rtl/rbus_slot_arbiter_if.sv | 34 +++
 rtl/rbus_rr_picker.sv | 27 ++
 rtl/rbus_slot_arbiter.sv | 96 +++++++++
 tb/tb_rbus_slot_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rbus_arb_pkg.sv
// Shared types and helpers for rbus lane arbiters.
// Lane word widths, slot state record and frame length clamp.
package rbus_arb_pkg;

  localparam int RBUS_CTRL_W = 12;
  localparam int RBUS_DATA_W = 72;
  localparam int GNT_W_MAX   = 4;
  localparam int LENQ_W      = 5;

  typedef struct packed {
    logic                 busy;
    logic [GNT_W_MAX-1:0] gnt_id;
    logic [LENQ_W-1:0]    len_q;
  } slot_st_t;

  // Zero-length frames still carry one word; never exceed the slot.
  function automatic logic [LENQ_W-1:0] len_clamp(
    input logic [15:0] len,
    input logic [15:0] fw
  );
    logic [LENQ_W-1:0] r;
    if (len == 16'd0)
      r = LENQ_W'(1);
    else if (len > fw)
      r = fw[LENQ_W-1:0];
    else
      r = len[LENQ_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/rbus_slot_arbiter_if.sv
// Requester side and lane side of the rbus slot arbiter.
// master drives requests and FIFO heads; slave is the arbiter.
interface rbus_slot_arbiter_if #(
  parameter int REQ_NUM = 4,
  parameter int LEN_W   = 4
);
  import rbus_arb_pkg::*;

  localparam int GW = $clog2(REQ_NUM);

  logic                   i_en;
  logic [REQ_NUM-1:0]     i_req;
  logic [LEN_W-1:0]       i_len  [REQ_NUM];
  logic [RBUS_CTRL_W-1:0] i_ctrl [REQ_NUM];
  logic [RBUS_DATA_W-1:0] i_data [REQ_NUM];

  logic [REQ_NUM-1:0]     o_rd;
  logic [GW-1:0]          o_gnt_id;
  logic                   o_busy;
  logic                   o_sof;
  logic [RBUS_CTRL_W-1:0] o_ctrl;
  logic [RBUS_DATA_W-1:0] o_data;

  modport master (
    output i_en, i_req, i_len, i_ctrl, i_data,
    input  o_rd, o_gnt_id, o_busy, o_sof, o_ctrl, o_data
  );

  modport slave (
    input  i_en, i_req, i_len, i_ctrl, i_data,
    output o_rd, o_gnt_id, o_busy, o_sof, o_ctrl, o_data
  );

endinterface

// File: rtl/rbus_rr_picker.sv
// Combinational round-robin picker.
// Searches upward from i_ptr+1, wrapping modulo N.
module rbus_rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_valid,
  output logic [W-1:0] o_idx
);

  always_comb begin
    int k;
    o_valid = 1'b0;
    o_idx   = '0;
    k       = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(i_ptr) + i) % N;
      if (!o_valid && i_req[k]) begin
        o_valid = 1'b1;
        o_idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/rbus_slot_arbiter.sv
// Time-division rbus lane scheduler: one frame slot per grant,
// round-robin at each frame boundary, registered lane output.
module rbus_slot_arbiter
  import rbus_arb_pkg::*;
#(
  parameter int REQ_NUM     = 4,
  parameter int FRAME_WORDS = 8,
  parameter int LEN_W       = 4
) (
  input  logic clk,
  input  logic rst,
  rbus_slot_arbiter_if.slave bus
);

  localparam int GW = $clog2(REQ_NUM);
  localparam int CW = $clog2(FRAME_WORDS);

  logic [CW-1:0]          r_cnt;
  logic [GW-1:0]          r_ptr;
  slot_st_t               r_slot;
  logic                   r_sof;
  logic [RBUS_CTRL_W-1:0] r_ctrl;
  logic [RBUS_DATA_W-1:0] r_data;

  logic                   w_bnd;
  logic                   w_pick_vld;
  logic [GW-1:0]          w_pick;
  logic [GW-1:0]          w_gnt;
  logic                   w_pop;
  logic [REQ_NUM-1:0]     w_rd;
  logic [LENQ_W-1:0]      w_len;
  logic                   w_unused;

  rbus_rr_picker #(
    .N (REQ_NUM)
  ) u_pick (
    .i_req   (bus.i_req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick)
  );

  assign w_gnt    = r_slot.gnt_id[GW-1:0];
  assign w_unused = ^r_slot.gnt_id;
  assign w_bnd    = (r_cnt == CW'(FRAME_WORDS - 1));
  assign w_pop    = r_slot.busy
                 && (LENQ_W'(r_cnt) < r_slot.len_q);
  assign w_len    = len_clamp(16'(bus.i_len[w_pick]),
                              16'(FRAME_WORDS));

  always_comb begin
    w_rd        = '0;
    w_rd[w_gnt] = w_pop;
  end

  // Slot owner only changes on the boundary cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_ptr  <= GW'(REQ_NUM - 1);
      r_slot <= '0;
    end else begin
      r_cnt <= w_bnd ? '0 : r_cnt + 1'b1;
      if (w_bnd) begin
        if (bus.i_en && w_pick_vld) begin
          r_slot.busy   <= 1'b1;
          r_slot.gnt_id <= GNT_W_MAX'(w_pick);
          r_slot.len_q  <= w_len;
          r_ptr         <= w_pick;
        end else begin
          r_slot.busy <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sof  <= 1'b0;
      r_ctrl <= '0;
      r_data <= '0;
    end else begin
      r_sof  <= w_pop && (r_cnt == '0);
      r_ctrl <= w_pop ? bus.i_ctrl[w_gnt] : '0;
      r_data <= w_pop ? bus.i_data[w_gnt] : '0;
    end
  end

  assign bus.o_rd     = w_rd;
  assign bus.o_gnt_id = w_gnt;
  assign bus.o_busy   = r_slot.busy;
  assign bus.o_sof    = r_sof;
  assign bus.o_ctrl   = r_ctrl;
  assign bus.o_data   = r_data;

endmodule

// File: tb/tb_rbus_slot_arbiter.sv
// Randomized scoreboard bench for rbus_slot_arbiter.
// Frame-level reference model predicts every output cycle.
module tb_rbus_slot_arbiter;

  localparam int N  = 4;
  localparam int FW = 8;
  localparam int LW = 4;
  localparam int GW = $clog2(N);

  typedef struct packed {
    logic [N-1:0]  rd;
    logic [GW-1:0] gid;
    logic          busy;
    logic          sof;
    logic [11:0]   ctrl;
    logic [71:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rbus_slot_arbiter_if #(.REQ_NUM(N), .LEN_W(LW)) bus ();

  rbus_slot_arbiter #(
    .REQ_NUM     (N),
    .FRAME_WORDS (FW),
    .LEN_W       (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;
  exp_t expq[$];
  int   seen_gnt[$];

  logic [83:0] src [N][256];
  int          seq [N];

  int m_w, m_own, m_len, m_last, m_gid;
  bit m_gnt;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_gnt = 1'b0; m_own = 0;
    m_len = 0; m_last = N - 1; m_gid = 0;
  endtask

  task automatic drive_heads();
    for (int n = 0; n < N; n++) begin
      bus.i_ctrl[n] = src[n][seq[n] % 256][83:72];
      bus.i_data[n] = src[n][seq[n] % 256][71:0];
    end
  endtask

  // One cycle: predict what the lane shows after the next edge.
  task automatic step();
    exp_t e;
    int   cl;
    int   c;
    e = '0;
    drive_heads();
    if (m_gnt && m_w < m_len) begin
      e.sof  = (m_w == 0);
      e.ctrl = src[m_own][seq[m_own] % 256][83:72];
      e.data = src[m_own][seq[m_own] % 256][71:0];
      seq[m_own]++;
    end
    if (m_w == FW - 1) begin
      m_gnt = 1'b0;
      if (bus.i_en && bus.i_req != '0) begin
        for (int i = 1; i <= N; i++) begin
          c = (m_last + i) % N;
          if (!m_gnt && bus.i_req[c]) begin
            m_gnt  = 1'b1;
            m_own  = c;
            m_gid  = c;
            m_last = c;
            cl     = int'(bus.i_len[c]);
            m_len  = (cl == 0) ? 1 : ((cl > FW) ? FW : cl);
          end
        end
      end
    end
    m_w    = (m_w + 1) % FW;
    e.busy = m_gnt;
    e.gid  = GW'(m_gid);
    e.rd   = (m_gnt && m_w < m_len) ? N'(1 << m_own) : '0;
    expq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic run(int cyc);
    for (int i = 0; i < cyc; i++) step();
  endtask

  task automatic set_all(logic [N-1:0] req, int len);
    bus.i_req = req;
    for (int n = 0; n < N; n++) bus.i_len[n] = LW'(len);
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    if (mon_on && expq.size() > 0) begin
      e = expq.pop_front();
      a.rd   = bus.o_rd;
      a.gid  = bus.o_gnt_id;
      a.busy = bus.o_busy;
      a.sof  = bus.o_sof;
      a.ctrl = bus.o_ctrl;
      a.data = bus.o_data;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL lane t=%0t got rd=%h gid=%0d busy=%b sof=%b ctrl=%h data=%h want rd=%h gid=%0d busy=%b sof=%b ctrl=%h data=%h",
                 $time, a.rd, a.gid, a.busy, a.sof, a.ctrl, a.data,
                 e.rd, e.gid, e.busy, e.sof, e.ctrl, e.data);
      end
      if (bus.o_sof) seen_gnt.push_back(int'(bus.o_gnt_id));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int order [5];
    int got;
    bit found;
    order = '{0, 1, 2, 3, 0};
    for (int n = 0; n < N; n++) begin
      seq[n] = 0;
      for (int k = 0; k < 256; k++)
        src[n][k] = {20'($urandom), $urandom, $urandom};
    end
    rst    = 1'b0;
    bus.i_en = 1'b1;
    set_all('0, 0);
    drive_heads();
    repeat (3) @(negedge clk);
    chk("rst_rd",   bus.o_rd, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_gid",  bus.o_gnt_id, 0);
    chk("rst_sof",  bus.o_sof, 0);
    chk("rst_data", {bus.o_ctrl, bus.o_data}, 0);
    #1;
    rst = 1'b1;
    model_reset();
    mon_on = 1'b1;

    run(3 * FW);

    seen_gnt.delete();
    set_all('1, 8);
    run(6 * FW);
    for (int i = 0; i < 5; i++) begin
      got = (i < seen_gnt.size()) ? seen_gnt[i] : 99;
      chk("gnt_order", got, order[i]);
    end

    set_all(4'b0100, 3);
    run(4 * FW);

    set_all(4'b0010, 0);
    run(2 * FW);
    set_all(4'b1000, 15);
    run(2 * FW);

    bus.i_req = '1;
    for (int n = 0; n < N; n++)
      bus.i_len[n] = LW'($urandom_range(1, 8));
    run(FW + 3);
    bus.i_en = 1'b0;
    run(FW);
    bus.i_en = 1'b1;
    run(3 * FW - 3);

    for (int i = 0; i < 40 * FW; i++) begin
      bus.i_en  = ($urandom_range(0, 7) != 0);
      bus.i_req = N'($urandom);
      for (int n = 0; n < N; n++)
        bus.i_len[n] = LW'($urandom_range(0, 15));
      step();
    end

    bus.i_en = 1'b1;
    set_all('1, 8);
    found = 1'b0;
    for (int i = 0; i < 5 * FW && !found; i++) begin
      if (m_gnt && m_w == 4) found = 1'b1;
      else step();
    end
    chk("mid_frame_found", found, 1);
    rst    = 1'b0;
    mon_on = 1'b0;
    expq.delete();
    #1;
    chk("arst_rd",   bus.o_rd, 0);
    chk("arst_busy", bus.o_busy, 0);
    chk("arst_sof",  bus.o_sof, 0);
    chk("arst_data", {bus.o_ctrl, bus.o_data}, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    seen_gnt.delete();
    mon_on = 1'b1;
    run(3 * FW);
    got = (seen_gnt.size() > 0) ? seen_gnt[0] : 99;
    chk("post_rst_first", got, 0);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
